// File: rtl/baluga_pkg.sv
// ----------------------------------------------------------------------------
// baluga_pkg
//   Shared definitions for the instruction ROM, the fetch unit and the decoder:
//   default address/instruction widths, the reset PC, the instruction and
//   PC types, and the fetch-stage occupancy helper.
// ----------------------------------------------------------------------------
package baluga_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 8;
  localparam int unsigned DEF_INSTR_WIDTH = 9;
  localparam int unsigned DEF_RESET_PC    = 0;

  typedef logic [DEF_INSTR_WIDTH-1:0] instr_t;
  typedef logic [DEF_ADDR_WIDTH-1:0]  pc_t;

  // Instruction word paired with the address it was fetched from.
  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_entry_t;

  // Entries the fetch stage will still hold after this edge, before any new
  // issue. A consume always implies a valid ir entry, so this never underflows.
  function automatic logic [1:0] fetch_occupancy(
    input logic ir_valid,
    input logic skid_valid,
    input logic inflight,
    input logic consume
  );
    logic [1:0] occ;
    occ = 2'(ir_valid) + 2'(skid_valid) + 2'(inflight) - 2'(consume);
    return occ;
  endfunction

endpackage : baluga_pkg

// File: rtl/fetch_skid_buffer.sv
// ----------------------------------------------------------------------------
// fetch_skid_buffer
//   Instruction register (head) backed by a single skid entry. A captured word
//   goes straight to the head when the head is empty or being taken this
//   cycle, otherwise it parks in the skid entry. When the head is taken the
//   skid entry refills it first, so order is preserved. flush empties both.
//
// Ports
//   clock         rising-edge clock
//   reset_n       synchronous active-low reset
//   flush         drop head and skid contents this edge
//   capture       capture_data is to be stored this edge
//   capture_data  word to store
//   ready         downstream takes the head this edge (when head_valid)
//   head_valid    head_data holds a valid word (registered)
//   head_data     current head word (registered)
//   skid_valid    skid entry occupied (registered)
// ----------------------------------------------------------------------------
module fetch_skid_buffer #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             capture,
  input  logic [WIDTH-1:0] capture_data,
  input  logic             ready,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             skid_valid
);

  logic [WIDTH-1:0] skid_data;
  logic             head_free_c;

  // Head can accept a new word when empty or when its current word leaves.
  assign head_free_c = ~head_valid | ready;

  // Head / skid update; the owner guarantees the skid is never overfilled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (head_free_c) begin
      if (skid_valid) begin
        head_valid <= 1'b1;
        head_data  <= skid_data;
        skid_valid <= capture;
        if (capture) begin
          skid_data <= capture_data;
        end
      end else begin
        head_valid <= capture;
        if (capture) begin
          head_data <= capture_data;
        end
      end
    end else if (capture) begin
      skid_valid <= 1'b1;
      skid_data  <= capture_data;
    end
  end

endmodule : fetch_skid_buffer

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Read-side master for the instruction ROM. Owns the program counter,
//   presents it on rom_address, captures the ROM word one cycle later and hands
//   instruction + PC to the decoder over a valid/ready link. Supports branch
//   redirect, sticky halt with drain, and downstream stall at one instruction
//   per cycle.
//
// Ports
//   clock            rising-edge clock
//   reset_n          synchronous active-low reset
//   rom_address      PC presented to the ROM (registered)
//   rom_instruction  ROM word for the address sampled at the previous edge
//   branch_taken     redirect pulse, branch_target valid with it
//   branch_target    redirect PC
//   halt             stop fetching, sticky until reset
//   ir_ready         decoder takes ir_instruction this cycle
//   ir_valid         ir_instruction/ir_pc valid (registered)
//   ir_instruction   instruction to the decoder (registered)
//   ir_pc            address ir_instruction was fetched from (registered)
//   done             halted with nothing left in flight or buffered (registered)
// ----------------------------------------------------------------------------
module instruction_fetch_unit
  import baluga_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned RESET_PC    = DEF_RESET_PC
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic [ADDR_WIDTH-1:0]  rom_address,
  input  logic [INSTR_WIDTH-1:0] rom_instruction,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   halt,
  input  logic                   ir_ready,
  output logic                   ir_valid,
  output logic [INSTR_WIDTH-1:0] ir_instruction,
  output logic [ADDR_WIDTH-1:0]  ir_pc,
  output logic                   done
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } ir_entry_t;

  localparam int unsigned ENTRY_WIDTH = $bits(ir_entry_t);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] issued_pc;
  logic                  inflight;
  logic                  halted;
  logic                  skid_valid;

  logic                  consume_c;
  logic                  redirect_c;
  logic                  issue_c;
  logic [1:0]            occ_c;
  ir_entry_t             capture_entry_c;
  ir_entry_t             head_entry;

  assign rom_address = pc;

  // A halt in the same cycle, or an earlier halt, suppresses the redirect.
  assign consume_c  = ir_valid & ir_ready;
  assign redirect_c = branch_taken & ~halt & ~halted;

  // Never hold more than two instructions between ir, skid and the ROM.
  assign occ_c   = fetch_occupancy(ir_valid, skid_valid, inflight, consume_c);
  assign issue_c = ~halted & ~halt & ~redirect_c & (occ_c < 2'd2);

  // The ROM word arriving now belongs to the address issued last edge.
  always_comb begin
    capture_entry_c       = '0;
    capture_entry_c.instr = rom_instruction;
    capture_entry_c.pc    = issued_pc;
  end

  // PC, issue tracking and halt state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc        <= RESET_PC_A;
      issued_pc <= '0;
      inflight  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (halt) begin
        halted <= 1'b1;
      end
      if (redirect_c) begin
        // The word returned for the previous issue is discarded.
        pc       <= branch_target;
        inflight <= 1'b0;
      end else begin
        inflight <= issue_c;
        if (issue_c) begin
          issued_pc <= pc;
          pc        <= pc + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Drained flag, one edge behind the state it summarises.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else begin
      done <= halted & ~ir_valid & ~skid_valid & ~inflight;
    end
  end

  // Instruction register plus one skid entry; a redirect flushes both.
  fetch_skid_buffer #(
    .WIDTH(ENTRY_WIDTH)
  ) u_skid (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (redirect_c),
    .capture      (inflight),
    .capture_data (capture_entry_c),
    .ready        (ir_ready),
    .head_valid   (ir_valid),
    .head_data    (head_entry),
    .skid_valid   (skid_valid)
  );

  assign ir_instruction = head_entry.instr;
  assign ir_pc          = head_entry.pc;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Self-checking bench for instruction_fetch_unit. A 1-cycle synchronous ROM
//   model feeds the DUT; a stream scoreboard (expected next PC, hold-stability
//   and throughput rules) runs every cycle, and directed scenario tasks check
//   latency, stall, redirect, wrap, halt/drain and mid-stream reset.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] rom_address;
  logic [8:0] rom_instruction;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       halt;
  logic       ir_ready;
  logic       ir_valid;
  logic [8:0] ir_instruction;
  logic [7:0] ir_pc;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [7:0] exp_pc;
  logic [7:0] hold_pc;
  logic [8:0] hold_instr;
  bit         halted_m;
  bit         prev_hold;
  bit         prev_flow;

  always #5 clock = ~clock;

  instruction_fetch_unit dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .halt            (halt),
    .ir_ready        (ir_ready),
    .ir_valid        (ir_valid),
    .ir_instruction  (ir_instruction),
    .ir_pc           (ir_pc),
    .done            (done)
  );

  function automatic logic [8:0] rom_f(input logic [7:0] a);
    return {1'b0, a} ^ 9'h155;
  endfunction

  always @(posedge clock) rom_instruction <= rom_f(rom_address);

  // Stream rules evaluated mid-cycle on the values the next edge will see.
  task automatic scoreboard();
    bit redir;
    if (reset_n !== 1'b1) begin
      exp_pc    = 8'h00;
      halted_m  = 1'b0;
      prev_hold = 1'b0;
      prev_flow = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== hold_pc || ir_instruction !== hold_instr) begin
          errors++;
          $display("FAIL hold_stable got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                   ir_valid, ir_pc, ir_instruction, hold_pc, hold_instr);
        end
      end
      if (prev_flow) begin
        checks++;
        if (ir_valid !== 1'b1) begin
          errors++;
          $display("FAIL throughput got ir_valid=%b want 1 after consume", ir_valid);
        end
      end
      redir = branch_taken && !halt && !halted_m;
      if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
        checks++;
        if (ir_pc !== exp_pc || ir_instruction !== rom_f(exp_pc)) begin
          errors++;
          $display("FAIL stream_order got pc=%h i=%h want pc=%h i=%h",
                   ir_pc, ir_instruction, exp_pc, rom_f(exp_pc));
        end
        exp_pc = exp_pc + 8'd1;
      end
      if (redir) exp_pc = branch_target;
      prev_hold  = (ir_valid === 1'b1) && !ir_ready && !redir;
      hold_pc    = ir_pc;
      hold_instr = ir_instruction;
      if (halt) halted_m = 1'b1;
      prev_flow = (ir_valid === 1'b1) && ir_ready && !redir && !halted_m;
    end
  endtask

  // One clock: scoreboard at the falling edge, then resume just after the rise.
  task automatic tick();
    @(negedge clock);
    scoreboard();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ir_ready = 1'b0; halt = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
    tick(); tick();
    checks++;
    if (ir_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags got v=%b done=%b want 0 0", ir_valid, done);
    end
    checks++;
    if (ir_instruction !== 9'h000 || ir_pc !== 8'h00) begin
      errors++; $display("FAIL reset_ir got i=%h pc=%h want 000 00", ir_instruction, ir_pc);
    end
    checks++;
    if (rom_address !== 8'h00) begin
      errors++; $display("FAIL reset_rom_address got %h want 00", rom_address);
    end
  endtask

  task automatic test_stream();
    reset_n = 1'b1; ir_ready = 1'b1;
    tick();
    checks++;
    if (ir_valid !== 1'b0 || rom_address !== 8'h01) begin
      errors++; $display("FAIL first_edge got v=%b addr=%h want 0 01", ir_valid, rom_address);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 8'(i) || ir_instruction !== rom_f(8'(i))) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h i=%h want 1 %h %h",
                 i, ir_valid, ir_pc, ir_instruction, 8'(i), rom_f(8'(i)));
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] got[$];
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 8'h03) begin
      errors++; $display("FAIL stall_start got v=%b pc=%h want 1 03", ir_valid, ir_pc);
    end
    ir_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 8'h03 || ir_instruction !== rom_f(8'h03)
          || rom_address !== 8'h05) begin
        errors++;
        $display("FAIL stall_hold_%0d got v=%b pc=%h i=%h addr=%h want 1 03 %h 05",
                 j, ir_valid, ir_pc, ir_instruction, rom_address, rom_f(8'h03));
      end
    end
    ir_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (ir_valid === 1'b1) got.push_back(ir_pc);
      tick();
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL stall_release_count got %0d want 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== 8'(3 + k)) begin
          errors++; $display("FAIL stall_release_%0d got %h want %h", k, got[k], 8'(3 + k));
        end
      end
    end
  endtask

  task automatic test_branch();
    bit found;
    found = 1'b0;
    ir_ready = 1'b1;
    for (int n = 0; n < 40 && !found; n++) begin
      if (rom_address === 8'h10) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL branch_reach_pc got %h want 10", rom_address);
    end
    branch_taken = 1'b1; branch_target = 8'h40;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || rom_address !== 8'h40) begin
      errors++; $display("FAIL branch_edge got v=%b addr=%h want 0 40", ir_valid, rom_address);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++; $display("FAIL branch_gap got v=%b want 0", ir_valid);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 8'(8'h40 + k) || ir_instruction !== rom_f(8'(8'h40 + k))) begin
        errors++;
        $display("FAIL branch_target_%0d got v=%b pc=%h want 1 %h", k, ir_valid, ir_pc, 8'(8'h40 + k));
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want;
    ir_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 8'hFE;
    tick();
    branch_taken = 1'b0;
    tick();
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_gap got v=%b want 0", ir_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      want = 8'(8'hFE + k);
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== want || ir_instruction !== rom_f(want)) begin
        errors++;
        $display("FAIL wrap_%0d got v=%b pc=%h i=%h want 1 %h %h",
                 k, ir_valid, ir_pc, ir_instruction, want, rom_f(want));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      ir_ready      = ($urandom_range(0, 9) < 6);
      branch_taken  = ($urandom_range(0, 19) == 0);
      branch_target = 8'($urandom);
      tick();
      if (ir_valid === 1'b1) begin
        checks++;
        if (ir_instruction !== rom_f(ir_pc)) begin
          errors++;
          $display("FAIL random_rom got i=%h want %h at pc=%h", ir_instruction, rom_f(ir_pc), ir_pc);
        end
      end
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_halt();
    int         hs_after;
    int         last_hs;
    int         done_edge;
    logic [7:0] frozen;
    hs_after = 0; last_hs = -1; done_edge = -1; frozen = 8'h00;
    ir_ready = 1'b1; branch_taken = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 24; k++) begin
      halt          = (k == 0);
      branch_taken  = (k == 0) || (k == 3);
      branch_target = (k == 0) ? 8'h80 : 8'hC0;
      ir_ready      = (k == 0 || k >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
      if (ir_valid === 1'b1 && ir_ready) begin
        last_hs = k;
        if (k > 0) hs_after++;
      end
      tick();
      if (k == 0) frozen = rom_address;
      checks++;
      if (done === 1'b1 && ir_valid !== 1'b0) begin
        errors++; $display("FAIL halt_done_with_valid at edge %0d", k);
      end
      if (done === 1'b1 && done_edge < 0) done_edge = k;
    end
    halt = 1'b0; branch_taken = 1'b0;
    checks++;
    if (hs_after > 2) begin
      errors++; $display("FAIL halt_extra got %0d instructions want at most 2", hs_after);
    end
    checks++;
    if (done_edge < 0 || done_edge != last_hs + 1) begin
      errors++; $display("FAIL halt_done_edge got %0d want %0d", done_edge, last_hs + 1);
    end
    checks++;
    if (done !== 1'b1 || ir_valid !== 1'b0 || rom_address !== frozen) begin
      errors++;
      $display("FAIL halt_final got done=%b v=%b addr=%h want 1 0 %h", done, ir_valid, rom_address, frozen);
    end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0; ir_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_clears_halt got done=%b want 0", done);
    end
    ir_ready = 1'b1;
    repeat (4) tick();
    ir_ready = 1'b0;
    tick(); tick();
    checks++;
    if (ir_valid !== 1'b1) begin
      errors++; $display("FAIL mid_precondition got v=%b want 1", ir_valid);
    end
    reset_n = 1'b0; ir_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h33;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || done !== 1'b0 || rom_address !== 8'h00 || ir_pc !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got v=%b done=%b addr=%h pc=%h want 0 0 00 00",
               ir_valid, done, rom_address, ir_pc);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++; $display("FAIL mid_restart_gap got v=%b want 0", ir_valid);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 8'(k) || ir_instruction !== rom_f(8'(k))) begin
        errors++;
        $display("FAIL mid_restart_%0d got v=%b pc=%h want 1 %h", k, ir_valid, ir_pc, 8'(k));
      end
    end
  endtask

  initial begin
    exp_pc = 8'h00; halted_m = 1'b0; prev_hold = 1'b0; prev_flow = 1'b0;
    hold_pc = 8'h00; hold_instr = 9'h000;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch_unit
